// File: rtl/legv8_fetch_unit.sv
// -----------------------------------------------------------------------------
// legv8_fetch_unit
//
// Instruction fetch stage for the LEGv8 core. It owns the program counter and
// drives the word address of Instruction_Memory_Thirty_Two_Bit. That memory
// registers its read, so the word for an address driven in cycle N appears on
// imem_data in cycle N+1. This unit tracks which address that returning word
// belongs to and whether it is still wanted. It then presents the word to
// decode as a (valid, pc, instr) triple.
//
// Ports
//   clk          : sole clock, rising edge
//   reset        : asynchronous, active-high reset
//   stall        : decode cannot accept the presented instruction this cycle
//   redirect     : taken branch/jump; next fetch comes from redirect_pc
//   redirect_pc  : redirect target
//   imem_addr    : word address to the instruction memory (combinational)
//   imem_data    : registered instruction word from the memory
//   if_valid     : if_pc/if_instr hold a real, non-squashed instruction
//   if_pc        : PC of the presented instruction
//   if_instr     : presented instruction (pass-through of imem_data)
//   fetch_count  : number of instructions accepted by decode (wraps at 16 bits)
// -----------------------------------------------------------------------------
module legv8_fetch_unit #(
    parameter int                     PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    PC_STEP  = 1,
    parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_data,
    output logic                if_valid,
    output logic [PC_WIDTH-1:0] if_pc,
    output logic [31:0]         if_instr,
    output logic [15:0]         fetch_count
);

    // pc_q      : next address to fetch
    // req_pc_q  : address whose word is currently on imem_data
    // req_valid_q : that word is real and not squashed
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] req_pc_q;
    logic                req_valid_q;

    logic [PC_WIDTH-1:0] pc_d;
    logic [PC_WIDTH-1:0] req_pc_d;
    logic                req_valid_d;
    logic                accept;

    // A stalled cycle re-reads the word already presented so that the
    // registered memory output, and therefore if_instr, stays put. A redirect
    // wins over the stall, so the normal fetch address is driven then. The
    // word read that cycle is squashed, so it does not matter which it is.
    always_comb begin
        if (stall && !redirect) begin
            imem_addr = req_pc_q;
        end else begin
            imem_addr = pc_q;
        end
    end

    // Decode consumes the presented instruction only when it is valid and
    // neither back-pressured nor flushed.
    assign accept = req_valid_q && !stall && !redirect;

    // Next-state selection, highest priority first: redirect, stall, advance.
    always_comb begin
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        req_valid_d = req_valid_q;
        if (redirect) begin
            // The word fetched this edge is wrong-path. Drop it and start
            // from the target. req_pc_q is don't-care while invalid.
            pc_d        = redirect_pc;
            req_valid_d = 1'b0;
        end else if (stall) begin
            pc_d        = pc_q;
            req_pc_d    = req_pc_q;
            req_valid_d = req_valid_q;
        end else begin
            // PC arithmetic is modulo 2^PC_WIDTH. The memory decodes only the
            // low address bits, so crossing its size aliases back to word 0.
            req_pc_d    = pc_q;
            req_valid_d = 1'b1;
            pc_d        = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= RESET_PC;
            req_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= '0;
        end else if (accept) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end

    // The memory output is registered already, so it is passed through.
    // if_valid marks whether the word is usable.
    assign if_instr = imem_data;
    assign if_pc    = req_pc_q;
    assign if_valid = req_valid_q;

endmodule

// File: doc/legv8_fetch_unit.md
# legv8_fetch_unit

Instruction fetch stage for the LEGv8 microprocessor. It sits directly upstream of `Instruction_Memory_Thirty_Two_Bit`: it owns the program counter, drives the memory's word address, and pairs each returned instruction with its PC and a valid flag for the decode stage. It also handles decode back-pressure (stall) and control-flow redirects (branch/jump), accounting for the memory's one-cycle registered read.

## Interface
- `PC_WIDTH`, 32: width of PC and memory address.
- `PC_STEP`, 1: PC increment per fetch. The memory is word-indexed on `address[4:0]`.
- `RESET_PC`, 0: PC value loaded by reset.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `stall` in 1: decode cannot accept this cycle; hold the presented instruction.
- `redirect` in 1: a taken branch/jump; the next fetch is from `redirect_pc`.
- `redirect_pc` in PC_WIDTH: redirect target.
- `imem_addr` out PC_WIDTH: address to the instruction memory `address` port (combinational).
- `imem_data` in 32: the memory's `instruction` output, registered by the memory.
- `if_valid` out 1: `if_instr`/`if_pc` hold a real, non-squashed instruction.
- `if_pc` out PC_WIDTH: PC of `if_instr`.
- `if_instr` out 32: the instruction, passed through from `imem_data`.
- `fetch_count` out 16: count of instructions accepted by decode.

## Operation
- State:
  - `pc_q`: next address to fetch.
  - `req_pc_q`: address whose data is currently on `imem_data`.
  - `req_valid_q`
  - `fetch_count`
- Reset values: `pc_q`=RESET_PC, `req_pc_q`=RESET_PC, `req_valid_q`=0, `fetch_count`=0. Outputs during reset: `if_valid`=0, `if_pc`=RESET_PC, `imem_addr`=RESET_PC.
- `imem_addr` = (`stall` && !`redirect`) ? `req_pc_q` : `pc_q`. While stalled, the memory re-reads the word already presented, so `if_instr` stays stable.
- Outputs: `if_instr` = `imem_data`, `if_pc` = `req_pc_q`, `if_valid` = `req_valid_q`.
- Per edge, in priority order:
  1. `redirect`=1: `pc_q`←`redirect_pc`, `req_valid_q`←0. The word fetched this edge is wrong-path and is squashed. `redirect` overrides `stall`.
  2. `stall`=1: `pc_q`, `req_pc_q` and `req_valid_q` hold.
  3. Otherwise: `req_pc_q`←`pc_q`, `req_valid_q`←1, `pc_q`←`pc_q`+PC_STEP.
- `fetch_count` increments on any edge where `if_valid`=1, `stall`=0 and `redirect`=0. It wraps 0xFFFF→0x0000.
- PC arithmetic is modulo 2^PC_WIDTH and has no explicit wrap logic. The memory uses only `address[4:0]`, so PC 31→32 aliases to word 0.

## Timing
- Fetch latency: an address driven in cycle N appears on `if_instr` in cycle N+1 with `if_valid`=1.
- After reset deasserts, the first edge fetches RESET_PC. `if_valid` rises after that first edge.
- Steady state: one instruction per cycle; `if_pc` advances by PC_STEP each cycle.
- Redirect penalty: exactly one bubble cycle (`if_valid`=0), then `if_pc`=`redirect_pc`.
- Stall: `if_valid`, `if_pc` and `if_instr` are held unchanged for every stalled cycle. On release, the held instruction is consumed and the sequence continues with no gap and no duplicate.
- Stall during a bubble (`req_valid_q`=0): the bubble is held; no fetch advances.
- Reset asserted mid-operation: all state clears immediately and asynchronously, regardless of stall/redirect. The in-flight memory word is ignored because `if_valid`=0.
- Simultaneous `stall` and `redirect`: the redirect is taken; `imem_addr`=`pc_q` that cycle.

## Test plan
- Memory model returns 0x1000_0000+index. Release reset and run 5 cycles → `if_pc` sequence 0,1,2,3,4 with `if_instr` 0x1000_0000..0x1000_0004, `if_valid`=1 from the first post-reset edge, `fetch_count`=5.
- `stall` high for 3 cycles while `if_pc`=2 → `if_pc`=2 and `if_instr`=0x1000_0002 held, `imem_addr`=2, `fetch_count` frozen. After release, `if_pc` goes 3,4 with no skip or duplicate.
- `redirect`=1, `redirect_pc`=12 while `if_pc`=5 → next cycle `if_valid`=0, then `if_pc`=12 with `if_instr`=0x1000_000C, then 13.
- `redirect` (pc 20) and `stall` asserted in the same cycle → redirect taken: one bubble, then `if_pc`=20.
- Assert `reset` asynchronously mid-stream, between clock edges → `if_valid`=0 and `imem_addr`=0 immediately. After release, the fetch sequence restarts at 0 and `fetch_count`=0.
- Preload `fetch_count` near wrap (run 65,536 accepted fetches) and `PC` across 31→32 → `fetch_count` wraps to 0, `if_pc`=32 returns memory word 0.
